// File: rtl/score_note_sequencer.sv
// rtl/score_note_sequencer.sv - filters pitch detections into timed notes and commits them to the renderer at frame start
// A single pending slot decouples note completion from the renderer's frame-aligned intake.
module score_note_sequencer #(
  parameter int TICK_DIV     = 2500000,
  parameter int STABLE_COUNT = 3,
  parameter int MAX_NOTES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_valid,
  input  logic [7:0] det_note,
  input  logic       frame_start,
  output logic [7:0] note,
  output logic [3:0] duration,
  output logic       note_dec,
  output logic [2:0] note_index,
  output logic       page_clear,
  output logic       overflow,
  output logic       busy
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0] LAST_SLOT = 3'(MAX_NOTES - 1);

  typedef enum logic {SILENT, TRACK} state_t;

  state_t          state_q, state_d;
  logic [7:0]      norm;
  logic [7:0]      cand, acc;
  logic [CW-1:0]   cand_cnt;
  logic [TW-1:0]   cyc;
  logic [3:0]      six;
  logic [7:0]      pending_note;
  logic [3:0]      pending_dur;
  logic            pending_v;
  logic            change, note_end, drain;
  logic [3:0]      end_dur;

  // Letters outside the seven naturals collapse to silence before filtering.
  always_comb begin
    case (det_note[7:4])
      4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'hA, 4'hB: norm = det_note;
      default:                                   norm = 8'h00;
    endcase
  end

  always_comb begin
    change   = (cand_cnt == CW'(STABLE_COUNT)) && (cand != acc);
    note_end = change && (state_q == TRACK);
    drain    = frame_start && pending_v;
    end_dur  = (six == 4'd0) ? 4'd1 : six;
    busy     = (state_q == TRACK) || pending_v;
  end

  always_comb begin
    state_d = state_q;
    if (change) state_d = (cand == 8'h00) ? SILENT : TRACK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SILENT;
      cand     <= 8'h00;
      cand_cnt <= '0;
      acc      <= 8'h00;
      cyc      <= '0;
      six      <= 4'd0;
    end else begin
      state_q <= state_d;
      if (det_valid) begin
        if (norm == cand) begin
          if (cand_cnt != CW'(STABLE_COUNT)) cand_cnt <= cand_cnt + 1'b1;
        end else begin
          cand     <= norm;
          cand_cnt <= CW'(1);
        end
      end
      if (change) acc <= cand;
      // Any change restarts timing so the next note measures from zero.
      if (change || state_q == SILENT) begin
        cyc <= '0;
        six <= 4'd0;
      end else if (cyc == TW'(TICK_DIV - 1)) begin
        cyc <= '0;
        if (six != 4'd15) six <= six + 4'd1;
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_note <= 8'h00;
      pending_dur  <= 4'd0;
      pending_v    <= 1'b0;
      overflow     <= 1'b0;
      note         <= 8'h00;
      duration     <= 4'd0;
      note_dec     <= 1'b0;
      note_index   <= 3'd0;
      page_clear   <= 1'b0;
    end else begin
      note_dec   <= drain;
      page_clear <= note_dec && (note_index == LAST_SLOT);
      if (drain) begin
        note      <= pending_note;
        duration  <= pending_dur;
        pending_v <= 1'b0;
      end
      // A drain in the same cycle frees the slot for the ending note.
      if (note_end) begin
        if (pending_v && !drain) begin
          overflow <= 1'b1;
        end else begin
          pending_note <= acc;
          pending_dur  <= end_dur;
          pending_v    <= 1'b1;
        end
      end
      if (note_dec) note_index <= (note_index == LAST_SLOT) ? 3'd0 : note_index + 3'd1;
    end
  end

endmodule
